// File: rtl/reg_writeback.sv
// reg_writeback: writeback stage and owner of the register-file write port.
//
// Retiring results from MEM are accepted over a valid/ready handshake into a
// small registered FIFO and committed one per cycle to the register file.
// A debug write request takes the port for the cycle and holds the FIFO.
// A 2-bit pending-write counter per register gives decode its hazard view.
//
// Ports
//   clk, rst                   clock; synchronous active-low reset
//   in_valid/in_ready          MEM result handshake (ready = FIFO not full)
//   in_rw, in_da, in_memtoreg, in_alu_result, in_mem_data,
//   in_fs, in_c/v/n/z          result payload
//   iss_valid, iss_rw, iss_da  decode issue; iss_ready low on saturated count
//   busy                       per-register pending-write flags
//   dbg_req, dbg_da, dbg_data  priority debug write
//   RW, DA, Writedata, FS, C/V/N/Z  register-file write and status port
//   retired                    count of committed FIFO entries
module reg_writeback #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_rw,
  input  logic [4:0]  in_da,
  input  logic        in_memtoreg,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_mem_data,
  input  logic [4:0]  in_fs,
  input  logic        in_c,
  input  logic        in_v,
  input  logic        in_n,
  input  logic        in_z,
  input  logic        iss_valid,
  input  logic        iss_rw,
  input  logic [4:0]  iss_da,
  output logic        iss_ready,
  output logic [31:0] busy,
  input  logic        dbg_req,
  input  logic [4:0]  dbg_da,
  input  logic [31:0] dbg_data,
  output logic        RW,
  output logic [4:0]  DA,
  output logic [31:0] Writedata,
  output logic [4:0]  FS,
  output logic        C,
  output logic        V,
  output logic        N,
  output logic        Z,
  output logic [31:0] retired
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic        rw;
    logic [4:0]  da;
    logic [31:0] data;
    logic [4:0]  fs;
    logic        c;
    logic        v;
    logic        n;
    logic        z;
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          head;
  entry_t          new_entry;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic [1:0]      pend [32];
  logic [31:0]     retired_q;

  logic full;
  logic empty;
  logic enq;
  logic commit;
  logic commit_rw;
  logic dec;
  logic iss_block;
  logic inc;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Outputs are forced to their reset values while rst is held low so the
  // register file and decode never see stale state during reset.
  assign in_ready = !rst || !full;
  assign enq      = rst && in_valid && !full;
  assign commit   = rst && !empty && !dbg_req;

  assign commit_rw = head.rw && (head.da != 5'd0);
  assign dec       = commit && commit_rw;

  // A commit to the same register this cycle frees a pending slot, so a
  // saturated counter does not block the issue in that case.
  assign iss_block = iss_rw && (iss_da != 5'd0) && (pend[iss_da] == 2'd3) &&
                     !(dec && (head.da == iss_da));
  assign iss_ready = !rst || !iss_block;
  assign inc       = rst && iss_valid && iss_rw && (iss_da != 5'd0) && !iss_block;

  assign retired = rst ? retired_q : '0;

  always_comb begin
    new_entry.rw   = in_rw;
    new_entry.da   = in_da;
    new_entry.data = in_memtoreg ? in_mem_data : in_alu_result;
    new_entry.fs   = in_fs;
    new_entry.c    = in_c;
    new_entry.v    = in_v;
    new_entry.n    = in_n;
    new_entry.z    = in_z;
  end

  always_comb begin
    busy = '0;
    for (int unsigned r = 1; r < 32; r++) begin
      busy[r] = rst && (pend[r] != 2'd0);
    end
  end

  always_comb begin
    RW        = 1'b0;
    DA        = '0;
    Writedata = '0;
    FS        = '0;
    C         = 1'b0;
    V         = 1'b0;
    N         = 1'b0;
    Z         = 1'b0;
    if (rst) begin
      if (dbg_req) begin
        RW        = 1'b1;
        DA        = dbg_da;
        Writedata = dbg_data;
      end else if (!empty) begin
        RW        = commit_rw;
        DA        = head.da;
        Writedata = head.data;
        // r31 doubles as the status register; the data write wins.
        FS        = (commit_rw && (head.da == 5'd31)) ? 5'd0 : head.fs;
        C         = head.c;
        V         = head.v;
        N         = head.n;
        Z         = head.z;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr] <= new_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      retired_q <= '0;
    end else begin
      if (enq) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (commit) begin
        rd_ptr    <= rd_ptr + 1'b1;
        retired_q <= retired_q + 32'd1;
      end
      case ({enq, commit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Commits to a register with no recorded issue leave its counter at zero.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned r = 0; r < 32; r++) begin
        pend[r] <= '0;
      end
    end else begin
      pend[0] <= '0;
      for (int unsigned r = 1; r < 32; r++) begin
        if (inc && (iss_da == 5'(r)) && !(dec && (head.da == 5'(r)))) begin
          pend[r] <= pend[r] + 2'd1;
        end else if (dec && (head.da == 5'(r)) && !(inc && (iss_da == 5'(r))) &&
                     (pend[r] != 2'd0)) begin
          pend[r] <= pend[r] - 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: expected register-file writes are queued
// by the stimulus and a monitor pops and compares on every cycle with RW=1.
module tb_reg_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_rw, in_memtoreg;
  logic [4:0]  in_da, in_fs;
  logic [31:0] in_alu_result, in_mem_data;
  logic        in_c, in_v, in_n, in_z;
  logic        iss_valid, iss_rw, iss_ready;
  logic [4:0]  iss_da;
  logic [31:0] busy;
  logic        dbg_req;
  logic [4:0]  dbg_da;
  logic [31:0] dbg_data;
  logic        RW;
  logic [4:0]  DA, FS;
  logic [31:0] Writedata, retired;
  logic        C, V, N, Z;

  always #5 clk = ~clk;

  reg_writeback #(.DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rw(in_rw), .in_da(in_da),
    .in_memtoreg(in_memtoreg), .in_alu_result(in_alu_result),
    .in_mem_data(in_mem_data), .in_fs(in_fs),
    .in_c(in_c), .in_v(in_v), .in_n(in_n), .in_z(in_z),
    .iss_valid(iss_valid), .iss_rw(iss_rw), .iss_da(iss_da),
    .iss_ready(iss_ready), .busy(busy),
    .dbg_req(dbg_req), .dbg_da(dbg_da), .dbg_data(dbg_data),
    .RW(RW), .DA(DA), .Writedata(Writedata), .FS(FS),
    .C(C), .V(V), .N(N), .Z(Z), .retired(retired)
  );

  typedef struct packed {
    logic [4:0]  da;
    logic [31:0] data;
    logic [4:0]  fs;
    logic [3:0]  cvnz;
  } wr_t;

  wr_t         exp_q[$];
  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  task automatic push(input logic [4:0] da, input logic [31:0] d, input logic [4:0] fs,
                      input logic [3:0] f);
    exp_q.push_back({da, d, fs, f});
  endtask

  // Drive one result at posedge+1 and hold it until accepted (bounded).
  task automatic enq(input logic rw, input logic [4:0] da, input logic m2r,
                     input logic [31:0] alu, input logic [31:0] md,
                     input logic [4:0] fs, input logic [3:0] f);
    logic rdy;
    in_valid = 1'b1; in_rw = rw; in_da = da; in_memtoreg = m2r;
    in_alu_result = alu; in_mem_data = md; in_fs = fs;
    {in_c, in_v, in_n, in_z} = f;
    rdy = 1'b0;
    for (int i = 0; i < 20 && !rdy; i++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
    end
    #1 in_valid = 1'b0;
    if (!rdy) check("enq_timeout", 64'(rdy), 64'(1));
  endtask

  task automatic iss(input logic [4:0] da, input logic exp_rdy, input string name);
    iss_valid = 1'b1; iss_rw = 1'b1; iss_da = da;
    @(negedge clk);
    check(name, 64'(iss_ready), 64'(exp_rdy));
    @(posedge clk);
    #1 iss_valid = 1'b0; iss_rw = 1'b0; iss_da = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every register-file write must match the next queued expectation.
  initial begin : monitor
    wr_t e;
    forever begin
      @(negedge clk);
      if (RW === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: got DA=%0d data=%h expected no write", DA, Writedata);
        end else begin
          e = exp_q.pop_front();
          check("write_port", 64'({DA, Writedata, FS, C, V, N, Z}), 64'(e));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst = 1'b0;
    in_valid = 0; in_rw = 0; in_da = '0; in_memtoreg = 0;
    in_alu_result = '0; in_mem_data = '0; in_fs = '0;
    {in_c, in_v, in_n, in_z} = '0;
    iss_valid = 0; iss_rw = 0; iss_da = '0;
    dbg_req = 0; dbg_da = '0; dbg_data = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_iss_ready", 64'(iss_ready), 64'(1));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_rw", 64'(RW), 64'(0));
    check("rst_retired", 64'(retired), 64'(0));
    @(posedge clk);
    #1 rst = 1'b1;

    // Basic ALU write, commits the cycle after acceptance
    push(5'd5, 32'h0000_1234, 5'd0, 4'b0000);
    enq(1'b1, 5'd5, 1'b0, 32'h1234, 32'hDEAD_BEEF, 5'd0, 4'b0000);
    @(negedge clk);
    check("t1_rw_next_cycle", 64'(RW), 64'(1));
    check("t1_da_next_cycle", 64'(DA), 64'(5));
    @(posedge clk);
    #1 check("t1_retired", 64'(retired), 64'(1));

    // r31 write suppresses FS; ordinary register keeps FS and flags
    push(5'd31, 32'hCAFE_F00D, 5'd0, 4'b1010);
    push(5'd7, 32'h0000_0077, 5'd3, 4'b0001);
    enq(1'b1, 5'd31, 1'b1, 32'h31, 32'hCAFE_F00D, 5'd3, 4'b1010);
    enq(1'b1, 5'd7, 1'b0, 32'h77, 32'h0, 5'd3, 4'b0001);
    idle(2);
    check("t2_retired", 64'(retired), 64'(3));

    // Debug writes take priority; FIFO fills and drains in order
    push(5'd2, 32'hD000_0001, 5'd0, 4'b0000);
    push(5'd3, 32'hD000_0002, 5'd0, 4'b0000);
    push(5'd4, 32'hD000_0003, 5'd0, 4'b0000);
    push(5'd10, 32'h0000_A0A0, 5'd0, 4'b0000);
    push(5'd11, 32'h0000_B0B0, 5'd2, 4'b0100);
    push(5'd12, 32'h0000_C0C0, 5'd0, 4'b0000);
    fork
      begin
        for (int i = 0; i < 3; i++) begin
          dbg_req = 1'b1; dbg_da = 5'(2 + i); dbg_data = 32'(32'hD000_0001 + i);
          @(posedge clk);
          #1;
        end
        dbg_req = 1'b0; dbg_da = '0; dbg_data = '0;
      end
      begin
        enq(1'b1, 5'd10, 1'b0, 32'hA0A0, 32'h0, 5'd0, 4'b0000);
        enq(1'b1, 5'd11, 1'b0, 32'hB0B0, 32'h0, 5'd2, 4'b0100);
        enq(1'b1, 5'd12, 1'b1, 32'h0, 32'hC0C0, 5'd0, 4'b0000);
      end
      begin
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("t3_in_ready_full", 64'(in_ready), 64'(0));
        check("t3_retired_hold", 64'(retired), 64'(3));
      end
    join
    idle(3);
    check("t3_retired", 64'(retired), 64'(6));

    // Scoreboard saturation and same-cycle increment/decrement
    check("t4_busy_init", 64'(busy), 64'(0));
    iss(5'd9, 1'b1, "t4_iss1");
    iss(5'd9, 1'b1, "t4_iss2");
    iss(5'd9, 1'b1, "t4_iss3");
    iss(5'd9, 1'b0, "t4_iss4_saturated");
    check("t4_busy9", 64'(busy), 64'(32'h0000_0200));
    push(5'd9, 32'h0000_0099, 5'd0, 4'b0000);
    enq(1'b1, 5'd9, 1'b0, 32'h99, 32'h0, 5'd0, 4'b0000);
    iss(5'd9, 1'b1, "t4_iss_with_commit");
    iss(5'd9, 1'b0, "t4_iss_still_saturated");
    check("t4_busy9_after", 64'(busy), 64'(32'h0000_0200));

    // r0 and rw=0 entries: no write, but they retire
    iss(5'd0, 1'b1, "t5_iss_r0");
    check("t5_busy_r0", 64'(busy), 64'(32'h0000_0200));
    enq(1'b1, 5'd0, 1'b0, 32'h55, 32'h0, 5'd0, 4'b0000);
    @(negedge clk);
    check("t5_rw_r0", 64'(RW), 64'(0));
    @(posedge clk);
    #1;
    enq(1'b0, 5'd6, 1'b0, 32'h66, 32'h0, 5'd5, 4'b0000);
    @(negedge clk);
    check("t5_rw_norw", 64'(RW), 64'(0));
    check("t5_fs_norw", 64'(FS), 64'(5));
    @(posedge clk);
    #1 check("t5_retired", 64'(retired), 64'(9));

    // Reset with queued entries and pending writes
    iss(5'd4, 1'b1, "t6_iss4");
    check("t6_busy", 64'(busy), 64'(32'h0000_0210));
    push(5'd1, 32'h0000_00DB, 5'd0, 4'b0000);
    push(5'd1, 32'h0000_00DB, 5'd0, 4'b0000);
    push(5'd1, 32'h0000_00DB, 5'd0, 4'b0000);
    dbg_req = 1'b1; dbg_da = 5'd1; dbg_data = 32'hDB;
    enq(1'b1, 5'd13, 1'b0, 32'h13, 32'h0, 5'd0, 4'b0000);
    enq(1'b1, 5'd14, 1'b0, 32'h14, 32'h0, 5'd0, 4'b0000);
    @(negedge clk);
    check("t6_full", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    dbg_req = 1'b0; dbg_da = '0; dbg_data = '0;
    iss_rw = 1'b1; iss_da = 5'd9;
    @(negedge clk);
    check("t6_in_reset_in_ready", 64'(in_ready), 64'(1));
    check("t6_in_reset_iss_ready", 64'(iss_ready), 64'(1));
    check("t6_in_reset_busy", 64'(busy), 64'(0));
    check("t6_in_reset_rw", 64'(RW), 64'(0));
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("t6_after_busy", 64'(busy), 64'(0));
    check("t6_after_rw", 64'(RW), 64'(0));
    check("t6_after_retired", 64'(retired), 64'(0));
    check("t6_after_in_ready", 64'(in_ready), 64'(1));
    check("t6_after_iss_ready", 64'(iss_ready), 64'(1));
    @(posedge clk);
    #1 iss_rw = 1'b0; iss_da = '0;
    idle(2);
    push(5'd12, 32'h0000_000C, 5'd0, 4'b0000);
    enq(1'b1, 5'd12, 1'b0, 32'hC, 32'h0, 5'd0, 4'b0000);
    idle(2);
    check("t6_retired_restart", 64'(retired), 64'(1));

    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
# reg_writeback

Writeback stage and write-port owner for the CPU register file. It accepts retiring results from the MEM stage over a valid/ready handshake and buffers them in a small FIFO. It drives the register file write port (RW/DA/Writedata) and the status-update inputs (FS, C/V/N/Z). It arbitrates that port against a priority debug write and keeps a per-register pending-write scoreboard that decode uses for hazard stalls.

## Interface
- DEPTH, 2: result FIFO entries (power of two, ≥2)
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous reset, active-low
- in_valid  in  1  MEM stage offers a result
- in_ready  out  1  FIFO can accept (not full)
- in_rw  in  1  result writes a register
- in_da  in  5  destination register
- in_memtoreg  in  1  1: write in_mem_data, 0: write in_alu_result
- in_alu_result  in  32  ALU result
- in_mem_data  in  32  load data
- in_fs  in  5  function select; nonzero requests status update
- in_c, in_v, in_n, in_z  in  1 each  status flags of the result
- iss_valid  in  1  decode issues an instruction
- iss_rw  in  1  issued instruction will write a register
- iss_da  in  5  its destination
- iss_ready  out  1  low when pending count for iss_da is saturated
- busy  out  32  bit r = register r has ≥1 pending write
- dbg_req  in  1  debug write request, highest priority
- dbg_da  in  5  debug destination
- dbg_data  in  32  debug data
- RW  out  1  register file write enable
- DA  out  5  register file write address
- Writedata  out  32  register file write data
- FS  out  5  status-update select to register file
- C, V, N, Z  out  1 each  flags to register file
- retired  out  32  count of FIFO entries committed

## Operation
- Enqueue when in_valid && in_ready. Data mux (memtoreg) resolves at enqueue. Entry stores {rw, da, data[31:0], fs, c, v, n, z}.
- in_ready = FIFO not full. A simultaneous dequeue does not free a slot in the same cycle.
- Commit happens when the FIFO is non-empty && !dbg_req. The head pops that cycle.
- Commit outputs: RW = head.rw && head.da != 0; DA = head.da; Writedata = head.data; C/V/N/Z = head flags.
- FS = head.fs, except FS = 0 when RW=1 && DA=31. The data write to r31 is the only r31 update.
- Debug cycle (dbg_req=1): RW=1, DA=dbg_da, Writedata=dbg_data, FS=0, flags 0. FIFO holds. Scoreboard and retired are unchanged. dbg_da=0 still drives RW=1 and is harmless.
- Idle (no commit, no debug): RW=0, FS=0, DA/Writedata/flags = 0.
- Scoreboard: 2-bit pending counter per register; r0 is always 0.
  - Counter +1 on iss_valid && iss_rw && iss_da!=0 && iss_ready.
  - Counter −1 on a commit with RW=1 to that register.
  - Same-cycle increment and decrement of one register leave it unchanged.
- iss_ready = 0 when iss_rw && iss_da!=0 && count[iss_da]==3 && no same-cycle decrement of iss_da. Otherwise 1.
- busy[r] = count[r] != 0.
- retired += 1 on every commit, including rw=0 and da=0 entries. Wraps at 2^32.

## Timing
- Registered FIFO. A result accepted in cycle t commits at the earliest in cycle t+1. The register file captures it at the end of t+1.
- Commit outputs and busy are combinational from head/state. No extra output register.
- Back-to-back accepts commit in consecutive cycles when dbg_req=0. Sustained throughput is 1 result/cycle.
- Each dbg_req cycle delays the head by one cycle. in_ready drops after DEPTH entries accumulate.
- The scoreboard clears in the commit cycle, so busy[r] falls in cycle t+1 after the clock edge that writes r. A decode read of r in that cycle sees the new value.
- Reset (rst=0 at a clock edge) empties the FIFO, clears all counters, clears retired, and discards in-flight entries. It overrides simultaneous enqueue, issue and commit.
- Outputs during and after reset: in_ready=1, iss_ready=1, busy=0, RW=0, DA=0, Writedata=0, FS=0, C=V=N=Z=0, retired=0.

## Test plan
- Accept {rw=1, da=5, memtoreg=0, alu=0x1234} in cycle 0 -> cycle 1 shows RW=1, DA=5, Writedata=0x00001234, FS=0; retired=1 afterwards.
- Accept da=31, fs=3, flags 1010 -> FS=0, Writedata=data. Then da=7, fs=3, Z=1 -> RW=1, FS=3, Z=1.
- Hold dbg_req=1 for 3 cycles while streaming 3 results -> debug writes appear first, in_ready low once 2 are queued, the results commit in order after release, and none are lost.
- Issue da=9 four times with no commits -> busy[9]=1, iss_ready=0 on the fourth. One commit to r9 with a same-cycle issue to r9 -> count stays 3.
- Issue/commit to da=0 -> RW=0, busy[0] stays 0, retired increments.
- Assert rst=0 with 2 queued and busy[4]=1 -> next cycle FIFO empty, busy=0, RW=0, retired=0, in_ready=1.
